// File: rtl/frankie_pkg.sv
// Shared types and constants for the Frankie main-memory arbiter.
package frankie_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_DONE   = 2'b10
  } arb_state_e;

  // Reload value for the access-latency counter (MEM_LAT is 1..7).
  function automatic logic [2:0] lat_init(input int mem_lat);
    return 3'(mem_lat - 1);
  endfunction

endpackage

// File: rtl/frankie_mem_arbiter_if.sv
// Requester and memory bus bundle for frankie_mem_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface frankie_mem_arbiter_if #(
  parameter int ADDR_W = frankie_pkg::ADDR_W,
  parameter int DATA_W = frankie_pkg::DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output io_ack, io_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  io_ack, io_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner, busy
  );
endinterface

// File: rtl/frankie_arb_pick.sv
// Combinational winner select between CPU and I/O requests.
// FRANKIE_ARB_RR_EN: round-robin on a tie; otherwise fixed CPU priority.
module frankie_arb_pick
  import frankie_pkg::*;
(
  input  logic cpu_req_i,
  input  logic io_req_i,
  input  logic last_owner_i,
  output logic winner_o
);

`ifdef FRANKIE_ARB_RR_EN
  // On a tie the requester not served last wins.
  always_comb begin
    winner_o = OWN_CPU;
    if (cpu_req_i && io_req_i) begin
      winner_o = ~last_owner_i;
    end else if (io_req_i) begin
      winner_o = OWN_IO;
    end else begin
      winner_o = OWN_CPU;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  // CPU wins every tie.
  always_comb begin
    winner_o = OWN_CPU;
    if (io_req_i && !cpu_req_i) begin
      winner_o = OWN_IO;
    end else begin
      winner_o = OWN_CPU;
    end
  end
`endif

endmodule

// File: rtl/frankie_mem_arbiter.sv
// Two-requester arbiter for Frankie's single-port main memory (IDLE/ACCESS/DONE).
// Tie policy selectable with FRANKIE_ARB_RR_EN (see frankie_arb_pick).
module frankie_mem_arbiter #(
  parameter int ADDR_W  = frankie_pkg::ADDR_W,
  parameter int DATA_W  = frankie_pkg::DATA_W,
  parameter int MEM_LAT = 1
) (
  input logic                  CLK,
  input logic                  Reset,
  frankie_mem_arbiter_if.slave bus
);
  import frankie_pkg::*;

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [2:0]        lat_q, lat_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              io_ack_q, io_ack_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic              winner_s;

  frankie_arb_pick u_pick (
    .cpu_req_i    (bus.cpu_req),
    .io_req_i     (bus.io_req),
    .last_owner_i (owner_q),
    .winner_o     (winner_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    io_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.cpu_req || bus.io_req) begin
          owner_d = winner_s;
          if (winner_s == OWN_IO) begin
            we_d    = bus.io_we;
            addr_d  = bus.io_addr;
            wdata_d = bus.io_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
          lat_d    = lat_init(MEM_LAT);
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = ARB_ACCESS;
        end else begin
          mem_en_d = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        if (lat_q == 3'd0) begin
          mem_en_d = 1'b0;
          state_d  = ARB_DONE;
          // Writes leave the requester's last read word in place.
          if (owner_q == OWN_IO) begin
            io_ack_d = 1'b1;
            if (!we_q) begin
              io_rdata_d = bus.mem_rdata;
            end else begin
              io_rdata_d = io_rdata_q;
            end
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) begin
              cpu_rdata_d = bus.mem_rdata;
            end else begin
              cpu_rdata_d = cpu_rdata_q;
            end
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d  = ARB_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IO;
      lat_q       <= 3'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      io_ack_q    <= io_ack_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
  assign bus.io_ack    = io_ack_q;
  assign bus.io_rdata  = io_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/frankie_mem_arbiter.md
# frankie_mem_arbiter

Shares Frankie's single-port main memory between two requesters: the CPU memory path, driven by the control unit's MemRead/MemWrite/MemDst selection, and the I/O block. It accepts one request at a time through a req/ack handshake and latches the request at grant. It sequences the memory through a fixed-latency access and returns read data with a one-cycle ack. The CPU control unit holds its state while `cpu_stall` is high.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- MEM_LAT, 1, memory read latency in cycles; legal range 1..7

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- io_req, io_we, io_addr, io_wdata, io_ack, io_rdata: same widths and meanings, for the I/O requester
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  current/last grant: 0 = CPU, 1 = I/O
- busy  out  1  high when the FSM is not IDLE

## Operation
- FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - Samples cpu_req and io_req.
  - If either is high, selects a winner and latches its we/addr/wdata into internal registers.
  - Sets owner, loads lat_cnt = MEM_LAT-1, and moves to ACCESS.
- ACCESS:
  - mem_en = 1, with mem_addr and mem_wdata taken from the latched registers.
  - mem_we equals the latched we, asserted only in the first ACCESS cycle.
  - lat_cnt decrements each cycle. When lat_cnt = 0, the arbiter captures mem_rdata into the rdata register and moves to DONE.
- DONE:
  - The owner's ack = 1 for exactly one cycle. That owner's rdata output presents the captured word (a write returns the last captured value).
  - Moves to IDLE.
- Requester rule: deassert req on the edge that ends its ack cycle. If req is still high in IDLE, it is treated as a new request.
- Changes to addr/we/wdata while a request is pending but not yet granted are observed only at grant. Changes after grant are ignored.
- Arbitration when both requests are high in IDLE: the CPU wins (fixed priority), unless FRANKIE_ARB_RR_EN is defined.
- A single request always wins immediately, regardless of mode.
- Reset, from any state (including mid-ACCESS):
  - state = IDLE; mem_en = mem_we = 0; both acks = 0.
  - rdata registers = 0; owner = 1; lat_cnt = 0.
  - Any in-flight access is abandoned with no ack. A request still held high is re-arbitrated from IDLE.

## Timing
- Latency: req seen high in IDLE at edge N → ack high during cycle N+MEM_LAT+1. Total occupancy per access is MEM_LAT+2 cycles.
- Back-to-back accesses always include one IDLE cycle. Maximum throughput is 1 access per MEM_LAT+2 cycles.
- mem_en is high for exactly MEM_LAT consecutive cycles per access. mem_we is high for exactly 1 cycle per write.
- ack is never high for both requesters in the same cycle. ack is never high for two consecutive cycles.
- All outputs except cpu_stall are registered.

## Configuration
- FRANKIE_ARB_RR_EN defined:
  - Round-robin on a tie: the requester that is not `owner` (the last served) wins.
  - After reset owner = 1, so the CPU wins the first tie.
  - Two persistent requesters alternate CPU, IO, CPU, IO, and so on.
- Undefined: fixed CPU priority. Under continuous cpu_req the I/O requester can starve; this is accepted.

## Structure
- Shared package frankie_pkg holds:
  - state enum ARB_IDLE/ARB_ACCESS/ARB_DONE
  - owner constants OWN_CPU = 0, OWN_IO = 1
  - default widths ADDR_W/DATA_W
- Sub-module frankie_arb_pick (combinational winner select) takes cpu_req, io_req and last owner, and returns a winner. It contains the only FRANKIE_ARB_RR_EN-dependent logic.

## Test plan
- CPU read, MEM_LAT=1: memory[0x0040] = 0xBEEF; cpu_req, cpu_we=0, cpu_addr=0x0040 → mem_en for 1 cycle; cpu_ack in cycle 3 after the request edge with cpu_rdata = 0xBEEF; io_ack stays 0.
- I/O write, MEM_LAT=3: io_we=1, io_addr=0x0100, io_wdata=0x1234 → mem_en for 3 cycles, mem_we for 1 cycle; io_ack after 5 cycles; memory[0x0100] = 0x1234.
- Simultaneous requests for 4 accesses, with macro → grant order CPU, IO, CPU, IO. Without macro → CPU, CPU, CPU, CPU, and io_ack never fires.
- Address change while waiting: io_req is held while the CPU is served, and io_addr changes 0x0010 → 0x0020 before grant → the memory sees 0x0020.
- Reset asserted mid-ACCESS (MEM_LAT=3, 2nd cycle) → next cycle mem_en = 0, no ack, owner = 1. cpu_req still high → the access restarts and cpu_ack returns after 5 cycles.
- cpu_stall: cpu_req is raised while the I/O access is busy → cpu_stall stays high every cycle until the cpu_ack cycle, where it is 0.
